// File: rtl/video_mixer.sv
// rtl/video_mixer.sv - pixel-rate sprite/tilemap priority compositor with CPU palette RAM
module video_mixer #(
    parameter int PAL_AW  = 10,
    parameter int LATENCY = 3
) (
    input  logic              CLK_32M,
    input  logic              RESET_N,
    input  logic              CE_PIX,
    input  logic              HBLK,
    input  logic              VBLK,
    input  logic [7:0]        SPR_PIX,
    input  logic [7:0]        BGA_PIX,
    input  logic              BGA_PRIO,
    input  logic [7:0]        BGB_PIX,
    input  logic              BGB_PRIO,
    input  logic [2:0]        LAYER_EN,
    input  logic [PAL_AW:0]   A,
    input  logic [15:0]       DIN,
    output logic [15:0]       DOUT,
    output logic              DOUT_VALID,
    input  logic [1:0]        BYTE_SEL,
    input  logic              PAL_CS,
    input  logic              MRD,
    input  logic              MWR,
    output logic [4:0]        R,
    output logic [4:0]        G,
    output logic [4:0]        B,
    output logic              HBLK_O,
    output logic              VBLK_O
);

    // Palette storage and its two synchronous read registers (no reset: contents survive)
    logic [15:0]       r_pal [0:(1<<PAL_AW)-1];
    logic [15:0]       r_pal_q;
    logic [15:0]       r_dout;
    logic [PAL_AW-1:0] w_cpu_addr;

    // S0 registered pixels and per-layer opaque flags
    logic [7:0]        r_s0_spr;
    logic [7:0]        r_s0_bga;
    logic [7:0]        r_s0_bgb;
    logic              r_s0_bga_prio;
    logic              r_s0_bgb_prio;
    logic              r_s0_spr_op;
    logic              r_s0_bga_op;
    logic              r_s0_bgb_op;

    // S1 resolved palette address
    logic [PAL_AW-1:0] w_s1_addr;
    logic [PAL_AW-1:0] r_s1_addr;

    // Blank flags {hblk, vblk} travel alongside the pixel: [0]=S0 .. [LATENCY]=output
    logic [LATENCY:0][1:0] r_blk;

    logic [4:0]        r_r;
    logic [4:0]        r_g;
    logic [4:0]        r_b;
    logic              w_unused;

    assign w_cpu_addr = A[PAL_AW:1];
    assign DOUT       = r_dout;
    assign DOUT_VALID = MRD & PAL_CS;
    assign R          = r_r;
    assign G          = r_g;
    assign B          = r_b;
    assign HBLK_O     = r_blk[LATENCY][1];
    assign VBLK_O     = r_blk[LATENCY][0];
    assign w_unused   = &{1'b0, A[0], r_pal_q[15]};

    // Dual-port palette: CPU byte-lane writes, read-first reads so video sees old data on collision
    always_ff @(posedge CLK_32M) begin
        if (MWR && PAL_CS) begin
            if (BYTE_SEL[1]) r_pal[w_cpu_addr][15:8] <= DIN[15:8];
            if (BYTE_SEL[0]) r_pal[w_cpu_addr][7:0]  <= DIN[7:0];
        end
        r_dout <= r_pal[w_cpu_addr];
        if (CE_PIX) r_pal_q <= r_pal[r_s1_addr];
    end

    // Priority resolve: first matching rule wins, backdrop is entry 0
    always_comb begin
        w_s1_addr = '0;
        if (r_s0_bga_op && r_s0_bga_prio)
            w_s1_addr = PAL_AW'({2'b01, r_s0_bga});
        else if (r_s0_bgb_op && r_s0_bgb_prio)
            w_s1_addr = PAL_AW'({2'b00, r_s0_bgb});
        else if (r_s0_spr_op)
            w_s1_addr = PAL_AW'({2'b10, r_s0_spr});
        else if (r_s0_bga_op)
            w_s1_addr = PAL_AW'({2'b01, r_s0_bga});
        else if (r_s0_bgb_op)
            w_s1_addr = PAL_AW'({2'b00, r_s0_bgb});
    end

    // Pixel pipeline: every stage advances only on CE_PIX; reset blanks the output at once
    always_ff @(posedge CLK_32M or negedge RESET_N) begin
        if (!RESET_N) begin
            r_s0_spr      <= '0;
            r_s0_bga      <= '0;
            r_s0_bgb      <= '0;
            r_s0_bga_prio <= 1'b0;
            r_s0_bgb_prio <= 1'b0;
            r_s0_spr_op   <= 1'b0;
            r_s0_bga_op   <= 1'b0;
            r_s0_bgb_op   <= 1'b0;
            r_s1_addr     <= '0;
            r_blk         <= '1;
            r_r           <= '0;
            r_g           <= '0;
            r_b           <= '0;
        end else if (CE_PIX) begin
            r_s0_spr      <= SPR_PIX;
            r_s0_bga      <= BGA_PIX;
            r_s0_bgb      <= BGB_PIX;
            r_s0_bga_prio <= BGA_PRIO;
            r_s0_bgb_prio <= BGB_PRIO;
            r_s0_spr_op   <= (SPR_PIX[3:0] != 4'd0) && LAYER_EN[2];
            r_s0_bga_op   <= (BGA_PIX[3:0] != 4'd0) && LAYER_EN[1];
            r_s0_bgb_op   <= (BGB_PIX[3:0] != 4'd0) && LAYER_EN[0];
            r_s1_addr     <= w_s1_addr;
            r_blk         <= {r_blk[LATENCY-1:0], {HBLK, VBLK}};
            if (|r_blk[LATENCY-1]) begin
                r_r <= '0;
                r_g <= '0;
                r_b <= '0;
            end else begin
                r_r <= r_pal_q[14:10];
                r_g <= r_pal_q[9:5];
                r_b <= r_pal_q[4:0];
            end
        end
    end

endmodule

// File: tb/tb_video_mixer.sv
// tb/tb_video_mixer.sv - randomized self-checking bench for video_mixer
module tb_video_mixer;

    logic        CLK_32M = 1'b0;
    logic        RESET_N = 1'b0;
    logic        CE_PIX = 1'b0;
    logic        HBLK = 1'b0;
    logic        VBLK = 1'b0;
    logic [7:0]  SPR_PIX = '0;
    logic [7:0]  BGA_PIX = '0;
    logic        BGA_PRIO = 1'b0;
    logic [7:0]  BGB_PIX = '0;
    logic        BGB_PRIO = 1'b0;
    logic [2:0]  LAYER_EN = 3'b111;
    logic [10:0] A = '0;
    logic [15:0] DIN = '0;
    logic [15:0] DOUT;
    logic        DOUT_VALID;
    logic [1:0]  BYTE_SEL = 2'b11;
    logic        PAL_CS = 1'b0;
    logic        MRD = 1'b0;
    logic        MWR = 1'b0;
    logic [4:0]  R, G, B;
    logic        HBLK_O, VBLK_O;

    video_mixer #(.PAL_AW(10), .LATENCY(3)) dut (
        .CLK_32M(CLK_32M), .RESET_N(RESET_N), .CE_PIX(CE_PIX), .HBLK(HBLK), .VBLK(VBLK),
        .SPR_PIX(SPR_PIX), .BGA_PIX(BGA_PIX), .BGA_PRIO(BGA_PRIO), .BGB_PIX(BGB_PIX),
        .BGB_PRIO(BGB_PRIO), .LAYER_EN(LAYER_EN), .A(A), .DIN(DIN), .DOUT(DOUT),
        .DOUT_VALID(DOUT_VALID), .BYTE_SEL(BYTE_SEL), .PAL_CS(PAL_CS), .MRD(MRD), .MWR(MWR),
        .R(R), .G(G), .B(B), .HBLK_O(HBLK_O), .VBLK_O(VBLK_O)
    );

    always #5 CLK_32M = ~CLK_32M;

    int n_err = 0;
    int n_chk = 0;

    // Reference state: palette contents and per-tick history of resolved address, blanks, fetched word
    logic [15:0] pal [0:1023];
    int          tick = 0;
    logic [9:0]  t_addr [0:8191];
    logic [1:0]  t_blk  [0:8191];
    logic [15:0] t_data [0:8191];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] resolve(input logic [7:0] spr, input logic [7:0] bga, input logic pa,
                                           input logic [7:0] bgb, input logic pb, input logic [2:0] en);
        bit a_op, b_op, s_op;
        a_op = (bga[3:0] != 0) && en[1];
        b_op = (bgb[3:0] != 0) && en[0];
        s_op = (spr[3:0] != 0) && en[2];
        if (a_op && pa) return {2'b01, bga};
        if (b_op && pb) return {2'b00, bgb};
        if (s_op)       return {2'b10, spr};
        if (a_op)       return {2'b01, bga};
        if (b_op)       return {2'b00, bgb};
        return 10'h000;
    endfunction

    // One clock: update the model for this edge, then compare outputs just after it
    task automatic step(input bit ce, input string tag);
        logic [15:0] exp_dout;
        logic [16:0] exp_pix;
        bit          rd;
        int          src;
        CE_PIX = ce;
        if (ce && RESET_N) begin
            tick++;
            t_addr[tick] = resolve(SPR_PIX, BGA_PIX, BGA_PRIO, BGB_PIX, BGB_PRIO, LAYER_EN);
            t_blk[tick]  = {HBLK, VBLK};
            if (tick >= 3) t_data[tick-2] = pal[t_addr[tick-2]];
        end
        exp_dout = pal[A[10:1]];
        rd = MRD && PAL_CS;
        if (MWR && PAL_CS) begin
            if (BYTE_SEL[1]) pal[A[10:1]][15:8] = DIN[15:8];
            if (BYTE_SEL[0]) pal[A[10:1]][7:0]  = DIN[7:0];
        end
        @(posedge CLK_32M);
        #1;
        src = tick - 3;
        if (src < 1)              exp_pix = {15'd0, 2'b11};
        else if (|t_blk[src])     exp_pix = {15'd0, t_blk[src]};
        else                      exp_pix = {t_data[src][14:0], 2'b00};
        check(tag, {R, G, B, HBLK_O, VBLK_O}, {15'd0, exp_pix});
        if (rd) check({tag, "_dout"}, DOUT, exp_dout);
    endtask

    task automatic cpu_wr(input logic [9:0] addr, input logic [15:0] data, input logic [1:0] bs);
        A = {addr, 1'b0}; DIN = data; BYTE_SEL = bs; PAL_CS = 1'b1; MWR = 1'b1;
        step(1'b0, "cpu_wr");
        MWR = 1'b0; PAL_CS = 1'b0;
    endtask

    task automatic set_pix(input logic [7:0] s, input logic [7:0] a, input logic pa,
                           input logic [7:0] b, input logic pb);
        SPR_PIX = s; BGA_PIX = a; BGA_PRIO = pa; BGB_PIX = b; BGB_PRIO = pb;
    endtask

    int hcnt, zcnt;

    initial begin
        // Reset state
        step(1'b0, "rst");
        step(1'b0, "rst");
        check("rst_rgb", {R, G, B}, 15'd0);
        check("rst_blank", {HBLK_O, VBLK_O}, 2'b11);
        RESET_N = 1'b1;

        // Fill palette with random words so the model knows every entry
        for (int i = 0; i < 1024; i++) cpu_wr(i[9:0], 16'($urandom), 2'b11);
        cpu_wr(10'h000, 16'h001F, 2'b11);
        cpu_wr(10'h2A5, 16'h7C00, 2'b11);
        cpu_wr(10'h1A3, 16'h03E0, 2'b11);

        // Sprite over low-priority A, then high-priority A over sprite
        LAYER_EN = 3'b111;
        set_pix(8'hA5, 8'hA3, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, "prio");
        check("prio_spr", {R, G, B}, {5'd31, 5'd0, 5'd0});
        BGA_PRIO = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, "prio");
        check("prio_a", {R, G, B}, {5'd0, 5'd31, 5'd0});

        // Backdrop, then everything disabled
        set_pix(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, "bd");
        check("backdrop", {R, G, B}, {5'd0, 5'd0, 5'd31});
        LAYER_EN = 3'b000;
        SPR_PIX = 8'h11;
        for (int i = 0; i < 4; i++) step(1'b1, "bd_off");
        check("layer_off", {R, G, B}, {5'd0, 5'd0, 5'd31});

        // Five blanked ticks must produce exactly five blanked output ticks
        LAYER_EN = 3'b111;
        set_pix(8'hA5, 8'h00, 1'b0, 8'h00, 1'b0);
        hcnt = 0; zcnt = 0;
        for (int i = 0; i < 14; i++) begin
            HBLK = (i >= 3 && i < 8);
            step(1'b1, "hblk");
            if (HBLK_O) hcnt++;
            if ({R, G, B} == 15'd0) zcnt++;
        end
        check("hblk_o_cnt", hcnt, 5);
        check("hblk_rgb_cnt", zcnt, 5);

        // Byte-lane write and readback
        cpu_wr(10'h3FF, 16'h1234, 2'b11);
        cpu_wr(10'h3FF, 16'hFFAB, 2'b01);
        A = {10'h3FF, 1'b0}; PAL_CS = 1'b1; MRD = 1'b1;
        step(1'b0, "rd");
        step(1'b0, "rd");
        check("byte_rd", DOUT, 16'h12AB);
        check("dout_valid_hi", DOUT_VALID, 1'b1);
        MRD = 1'b0; PAL_CS = 1'b0;
        #1;
        check("dout_valid_lo", DOUT_VALID, 1'b0);

        // Collision: the write lands on the edge where the video fetches the same word
        set_pix(8'hA5, 8'h00, 1'b0, 8'h00, 1'b0);
        step(1'b1, "coll");
        step(1'b1, "coll");
        A = {10'h2A5, 1'b0}; DIN = 16'h0011; BYTE_SEL = 2'b11; PAL_CS = 1'b1; MWR = 1'b1;
        step(1'b1, "coll");
        MWR = 1'b0; PAL_CS = 1'b0;
        step(1'b1, "coll");
        check("coll_old", {R, G, B}, {5'd31, 5'd0, 5'd0});
        step(1'b1, "coll");
        check("coll_new", {R, G, B}, {5'd0, 5'd0, 5'd17});

        // Stall: no CE_PIX for ten cycles while inputs churn
        for (int i = 0; i < 10; i++) begin
            set_pix(8'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
            HBLK = 1'($urandom); VBLK = 1'($urandom);
            step(1'b0, "stall");
        end
        HBLK = 1'b0; VBLK = 1'b0;

        // Asynchronous reset between edges, then recovery
        #2;
        RESET_N = 1'b0;
        tick = 0;
        #1;
        check("arst_rgb", {R, G, B}, 15'd0);
        check("arst_hblk", HBLK_O, 1'b1);
        step(1'b0, "arst");
        step(1'b0, "arst");
        RESET_N = 1'b1;
        set_pix(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, "resume");
        check("rst_resume", {R, G, B, HBLK_O}, {5'd0, 5'd0, 5'd31, 1'b0});

        // Randomized traffic: sparse CE, blanking, layer masks, CPU reads and writes
        for (int i = 0; i < 3000; i++) begin
            set_pix(8'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                SPR_PIX[3:0] = 4'd0; BGA_PIX[3:0] = 4'd0;
            end
            HBLK = ($urandom_range(0, 9) == 0);
            VBLK = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 15) == 0) LAYER_EN = 3'($urandom);
            A = {10'($urandom), 1'b0};
            DIN = 16'($urandom);
            BYTE_SEL = 2'($urandom);
            PAL_CS = ($urandom_range(0, 2) == 0);
            MWR = ($urandom_range(0, 1) == 0);
            MRD = !MWR;
            step($urandom_range(0, 9) < 7, "rand");
        end
        PAL_CS = 1'b0; MWR = 1'b0; MRD = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
